// File: rtl/loc_scanner_pkg.sv
// Shared coordinate widths, grid size and location payload types for the
// world-state location scanner.
package loc_scanner_pkg;

  localparam int unsigned X_bits   = 8;
  localparam int unsigned Y_bits   = 7;
  localparam int unsigned PIXELS_X = 160;
  localparam int unsigned PIXELS_Y = 120;

  typedef struct packed {
    logic [X_bits-1:0] x;
    logic [Y_bits-1:0] y;
  } loc_t;

  typedef struct packed {
    logic valid;
    loc_t loc;
  } loc_tag_t;

endpackage

// File: rtl/loc_delay_line.sv
// Fixed-latency shift register carrying tagged locations from view issue
// to write-back; cleared asynchronously so in-flight entries are discarded.
module loc_delay_line
  import loc_scanner_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  loc_tag_t din,
  output loc_tag_t dout
);

  localparam int unsigned LAST = N - 1;

  loc_tag_t stage_q [N];
  loc_tag_t stage_d [N];

  // Shift every cycle; stage 0 takes the freshly issued location.
  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = din;
    for (int unsigned i = 1; i < N; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '{default: '0};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[LAST];

endmodule

// File: rtl/loc_scanner.sv
// Raster address generator: sweeps the view grid x-fastest and replays each
// issued coordinate PIPE_LAT cycles later as a write-back location.
module loc_scanner #(
  parameter int unsigned PIXELS_X       = loc_scanner_pkg::PIXELS_X,
  parameter int unsigned PIXELS_Y       = loc_scanner_pkg::PIXELS_Y,
  parameter int unsigned PIPE_LAT       = 2,
  parameter int unsigned FRAME_CTR_bits = 16
) (
  input  logic                              Clk,
  input  logic                              RESET_SIM_n,
  input  logic                              HOLD_VIEWLOC,
  input  logic                              HOLD_WRITELOC,
  output logic [loc_scanner_pkg::X_bits-1:0] viewLoc_x,
  output logic [loc_scanner_pkg::Y_bits-1:0] viewLoc_y,
  output logic                              view_valid,
  output logic [loc_scanner_pkg::X_bits-1:0] writeLoc_x,
  output logic [loc_scanner_pkg::Y_bits-1:0] writeLoc_y,
  output logic                              write_en,
  output logic                              frame_start,
  output logic                              frame_done,
  output logic [FRAME_CTR_bits-1:0]         frame_count
);

  import loc_scanner_pkg::*;

  localparam int unsigned X_W = X_bits;
  localparam int unsigned Y_W = Y_bits;
  localparam int unsigned F_W = FRAME_CTR_bits;

  localparam logic [X_W-1:0] X_LAST = X_W'(PIXELS_X - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(PIXELS_Y - 1);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [F_W-1:0] frame_count_q, frame_count_d;

  loc_tag_t tag_in;
  loc_tag_t tag_out;

  // Issue side is combinational from the held raster position.
  always_comb begin
    view_valid  = ~HOLD_VIEWLOC;
    frame_start = view_valid && (x_q == '0) && (y_q == '0);
  end

  // Raster advance, x-fastest with full-frame wrap.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (view_valid) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + Y_W'(1);
      end else begin
        x_d = x_q + X_W'(1);
      end
    end
  end

  always_comb begin
    tag_in       = '0;
    tag_in.valid = view_valid;
    tag_in.loc.x = x_q;
    tag_in.loc.y = y_q;
  end

  loc_delay_line #(
    .N (PIPE_LAT)
  ) u_delay (
    .clk   (Clk),
    .rst_n (RESET_SIM_n),
    .din   (tag_in),
    .dout  (tag_out)
  );

  // A write suppressed by HOLD_WRITELOC is dropped, never retried.
  always_comb begin
    write_en      = tag_out.valid & ~HOLD_WRITELOC;
    frame_done    = write_en && (tag_out.loc.x == X_LAST) && (tag_out.loc.y == Y_LAST);
    frame_count_d = frame_count_q + (frame_done ? F_W'(1) : F_W'(0));
  end

  always_ff @(posedge Clk or negedge RESET_SIM_n) begin
    if (!RESET_SIM_n) begin
      x_q           <= '0;
      y_q           <= '0;
      frame_count_q <= '0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign viewLoc_x   = x_q;
  assign viewLoc_y   = y_q;
  assign writeLoc_x  = tag_out.loc.x;
  assign writeLoc_y  = tag_out.loc.y;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_loc_scanner.sv
// Scoreboard bench for loc_scanner: stimulus queues expected view/write
// records, a negedge monitor pops and compares them against the DUT.
module tb_loc_scanner;

  localparam int PX   = 160;
  localparam int PY   = 120;
  localparam int PIPE = 2;

  logic       Clk;
  logic       rst_n;
  logic       HOLD_VIEWLOC;
  logic       HOLD_WRITELOC;
  logic [7:0] viewLoc_x, writeLoc_x;
  logic [6:0] viewLoc_y, writeLoc_y;
  logic       view_valid, write_en, frame_start, frame_done;
  logic [15:0] frame_count;

  logic       rst2_n, hv2, hw2;
  logic [7:0] v2x, w2x;
  logic [6:0] v2y, w2y;
  logic       vv2, we2, fs2, fd2;
  logic [1:0] fc2;

  loc_scanner dut (
    .Clk(Clk), .RESET_SIM_n(rst_n), .HOLD_VIEWLOC(HOLD_VIEWLOC), .HOLD_WRITELOC(HOLD_WRITELOC),
    .viewLoc_x(viewLoc_x), .viewLoc_y(viewLoc_y), .view_valid(view_valid),
    .writeLoc_x(writeLoc_x), .writeLoc_y(writeLoc_y), .write_en(write_en),
    .frame_start(frame_start), .frame_done(frame_done), .frame_count(frame_count)
  );

  loc_scanner #(.PIXELS_X(8), .PIXELS_Y(4), .PIPE_LAT(2), .FRAME_CTR_bits(2)) dut_small (
    .Clk(Clk), .RESET_SIM_n(rst2_n), .HOLD_VIEWLOC(hv2), .HOLD_WRITELOC(hw2),
    .viewLoc_x(v2x), .viewLoc_y(v2y), .view_valid(vv2),
    .writeLoc_x(w2x), .writeLoc_y(w2y), .write_en(we2),
    .frame_start(fs2), .frame_done(fd2), .frame_count(fc2)
  );

  typedef struct {
    int   t;
    logic v;
    int   x;
    int   y;
    logic fs;
  } view_rec_t;

  typedef struct {
    int due;
    int x;
    int y;
  } write_rec_t;

  view_rec_t  vq[$];
  write_rec_t wq[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ex       = 0;
  int ey       = 0;
  int bubbles  = 0;
  int fd_seen  = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Drive one cycle of holds, queue what the DUT must show, advance the model.
  task automatic step(input logic hv, input logic hw);
    view_rec_t  v;
    write_rec_t w;
    HOLD_VIEWLOC  = hv;
    HOLD_WRITELOC = hw;
    v.t  = cyc;
    v.v  = !hv;
    v.x  = ex;
    v.y  = ey;
    v.fs = !hv && ex == 0 && ey == 0;
    vq.push_back(v);
    if (!hv) begin
      w.due = cyc + PIPE;
      w.x   = ex;
      w.y   = ey;
      wq.push_back(w);
    end
    cyc++;
    @(posedge Clk);
    #1;
    if (!hv) begin
      if (ex == PX - 1) begin
        ex = 0;
        ey = (ey == PY - 1) ? 0 : ey + 1;
      end else begin
        ex = ex + 1;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_view_x", int'(viewLoc_x), 0);
    chk("rst_view_y", int'(viewLoc_y), 0);
    chk("rst_write_x", int'(writeLoc_x), 0);
    chk("rst_write_y", int'(writeLoc_y), 0);
    chk("rst_write_en", int'(write_en), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_frame_count", int'(frame_count), 0);
    vq.delete();
    wq.delete();
    @(posedge Clk);
    #1;
    rst_n = 1'b1;
    ex  = 0;
    ey  = 0;
    cyc = 0;
  endtask

  // Monitor: one view record per stepped cycle; write side matched by due cycle.
  always @(negedge Clk) begin
    view_rec_t  v;
    write_rec_t w;
    logic       en_e;
    int         wx, wy;
    if (rst_n && vq.size() > 0) begin
      v = vq.pop_front();
      chk("view_valid", int'(view_valid), int'(v.v));
      chk("view_x", int'(viewLoc_x), v.x);
      chk("view_y", int'(viewLoc_y), v.y);
      chk("frame_start", int'(frame_start), int'(v.fs));
      en_e = 1'b0;
      wx = 0;
      wy = 0;
      while (wq.size() > 0 && wq[0].due < v.t) begin
        chk("write_overdue", wq[0].due, v.t);
        void'(wq.pop_front());
      end
      if (wq.size() > 0 && wq[0].due == v.t) begin
        w    = wq.pop_front();
        en_e = !HOLD_WRITELOC;
        wx   = w.x;
        wy   = w.y;
      end
      chk("write_en", int'(write_en), int'(en_e));
      if (en_e) begin
        chk("write_x", int'(writeLoc_x), wx);
        chk("write_y", int'(writeLoc_y), wy);
      end
      chk("frame_done", int'(frame_done), int'(en_e && wx == PX - 1 && wy == PY - 1));
      if (!write_en) bubbles++;
      if (frame_done) fd_seen++;
    end
  end

  initial begin
    int g;
    int fc_exp [4];
    fc_exp[0] = 1; fc_exp[1] = 2; fc_exp[2] = 3; fc_exp[3] = 0;
    rst_n = 1'b0;
    rst2_n = 1'b0;
    hv2 = 1'b0;
    hw2 = 1'b0;
    HOLD_VIEWLOC = 1'b0;
    HOLD_WRITELOC = 1'b0;
    #2;
    do_reset();

    // Full frame plus pipeline drain with directed spot checks.
    for (int i = 0; i < PX * PY + PIPE; i++) begin
      if (i == 0) begin
        chk("c0_frame_start", int'(frame_start), 1);
        chk("c0_view_x", int'(viewLoc_x), 0);
      end
      if (i == 2) begin
        chk("c2_write_en", int'(write_en), 1);
        chk("c2_write_x", int'(writeLoc_x), 0);
        chk("c2_write_y", int'(writeLoc_y), 0);
      end
      if (i == 161) begin
        chk("c161_view_x", int'(viewLoc_x), 1);
        chk("c161_view_y", int'(viewLoc_y), 1);
      end
      if (i == 19199) begin
        chk("last_view_x", int'(viewLoc_x), 159);
        chk("last_view_y", int'(viewLoc_y), 119);
      end
      if (i == 19200) chk("c19200_frame_start", int'(frame_start), 1);
      if (i == 19201) begin
        chk("c19201_frame_done", int'(frame_done), 1);
        chk("c19201_write_x", int'(writeLoc_x), 159);
        chk("c19201_write_y", int'(writeLoc_y), 119);
      end
      step(1'b0, 1'b0);
    end
    chk("frame_done_pulses", fd_seen, 1);
    chk("frame_count_1", int'(frame_count), 1);

    // View hold for 5 cycles at (37,4).
    g = 0;
    while (!(ex == 37 && ey == 4) && g < 2000) begin
      step(1'b0, 1'b0);
      g++;
    end
    chk("hold_at_x", int'(viewLoc_x), 37);
    chk("hold_at_y", int'(viewLoc_y), 4);
    bubbles = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0);
      chk("held_x", int'(viewLoc_x), 37);
      chk("held_y", int'(viewLoc_y), 4);
    end
    step(1'b0, 1'b0);
    chk("resume_x", int'(viewLoc_x), 38);
    chk("resume_y", int'(viewLoc_y), 4);
    step(1'b0, 1'b0);
    chk("bubble_count", bubbles, 5);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);

    // Mid-frame asynchronous reset at (80,60).
    g = 0;
    while (!(ex == 80 && ey == 60) && g < 20000) begin
      step(1'b0, 1'b0);
      g++;
    end
    chk("pre_reset_x", int'(viewLoc_x), 80);
    chk("pre_reset_y", int'(viewLoc_y), 60);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i == 1) chk("post_rst_c1_write_en", int'(write_en), 0);
      if (i == 2) begin
        chk("post_rst_write_en", int'(write_en), 1);
        chk("post_rst_write_x", int'(writeLoc_x), 0);
        chk("post_rst_write_y", int'(writeLoc_y), 0);
      end
      step(1'b0, 1'b0);
    end

    // Write hold from reset until the setup controller's release point.
    do_reset();
    g = 0;
    while (!(ex >= 2 && ey == 1) && g < 1000) begin
      step(1'b0, 1'b1);
      g++;
    end
    HOLD_WRITELOC = 1'b0;
    #1;
    chk("release_view_x", int'(viewLoc_x), 2);
    chk("release_write_en", int'(write_en), 1);
    chk("release_write_x", int'(writeLoc_x), ex - 2);
    chk("release_write_y", int'(writeLoc_y), ey);
    for (int i = 0; i < 200; i++) step(1'b0, 1'b0);

    // Small-grid instance: 2-bit frame counter wraps after four frames.
    @(posedge Clk);
    #1;
    rst2_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      g = 0;
      do begin
        @(negedge Clk);
        g++;
      end while (!fd2 && g < 200);
      chk("small_frame_done_seen", int'(fd2), 1);
      @(posedge Clk);
      #1;
      chk("small_frame_count", int'(fc2), fc_exp[k]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
